// File: rtl/pc_src_ctrl.sv
// Multicycle PC-update sequencer: drives the PC source mux select and the PC/EPC load enables.
// Optional exception path (EPC save, vector read wait, vector jump) is enabled by `PC_SRC_CTRL_EXC_EN.
module pc_src_ctrl #(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] br_type,
    input  logic       alu_zero,
    input  logic       exc_req,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       epc_write,
    output logic       busy,
    output logic       done
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_mem_lat_range
        $error("pc_src_ctrl: MEM_LAT must be in 1..15");
    end

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_BEQ  = 2'd1;
    localparam logic [1:0] BR_BNE  = 2'd2;
    localparam logic [1:0] BR_J    = 2'd3;

`ifdef PC_SRC_CTRL_EXC_EN
    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, RESOLVE, EXC_SAVE, EXC_WAIT, EXC_JUMP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    logic [3:0] cnt_reg, cnt_next;
`else
    typedef enum logic [1:0] {
        IDLE, FETCH, DECODE, RESOLVE
    } state_t;

    logic unused_exc_req;
    assign unused_exc_req = exc_req;
`endif

    state_t     state_reg, state_next;
    logic [1:0] br_type_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            br_type_reg <= BR_NONE;
        end else begin
            state_reg <= state_next;
            if (state_reg == DECODE) begin
                br_type_reg <= br_type;
            end
        end
    end

`ifdef PC_SRC_CTRL_EXC_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= 4'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        pc_src     = 2'd0;
        pc_write   = 1'b0;
        epc_write  = 1'b0;
        busy       = (state_reg != IDLE);
        done       = 1'b0;
`ifdef PC_SRC_CTRL_EXC_EN
        cnt_next   = cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                pc_write   = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
`ifdef PC_SRC_CTRL_EXC_EN
                // Exception wins over whatever branch class was decoded.
                state_next = exc_req ? EXC_SAVE : RESOLVE;
`else
                state_next = RESOLVE;
`endif
            end
            RESOLVE: begin
                done       = 1'b1;
                state_next = IDLE;
                case (br_type_reg)
                    BR_BEQ: begin
                        pc_src   = 2'd1;
                        pc_write = alu_zero;
                    end
                    BR_BNE: begin
                        pc_src   = 2'd1;
                        pc_write = !alu_zero;
                    end
                    BR_J: begin
                        pc_src   = 2'd2;
                        pc_write = 1'b1;
                    end
                    default: begin
                        pc_write = 1'b0;
                    end
                endcase
            end
`ifdef PC_SRC_CTRL_EXC_EN
            EXC_SAVE: begin
                epc_write  = 1'b1;
                cnt_next   = CNT_INIT;
                state_next = EXC_WAIT;
            end
            EXC_WAIT: begin
                // Select the vector input early so the mux path settles while memory responds.
                pc_src = 2'd3;
                if (cnt_reg == 4'd0) begin
                    state_next = EXC_JUMP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            EXC_JUMP: begin
                pc_src     = 2'd3;
                pc_write   = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_src_ctrl.sv
// Scoreboard bench for pc_src_ctrl: stimulus pushes per-cycle expected outputs, a monitor pops and compares.
// Exception-path expectations follow `PC_SRC_CTRL_EXC_EN, matching the DUT build.
module tb_pc_src_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] br_type;
    logic       alu_zero;
    logic       exc_req;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       epc_write;
    logic       busy;
    logic       done;

    pc_src_ctrl #(.MEM_LAT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .br_type   (br_type),
        .alu_zero  (alu_zero),
        .exc_req   (exc_req),
        .pc_src    (pc_src),
        .pc_write  (pc_write),
        .epc_write (epc_write),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Expected vector layout: {pc_src[1:0], pc_write, epc_write, busy, done}
    localparam logic [5:0] V_IDLE  = 6'b00_0_0_0_0;
    localparam logic [5:0] V_FETCH = 6'b00_1_0_1_0;
    localparam logic [5:0] V_DEC   = 6'b00_0_0_1_0;
    localparam logic [5:0] V_NONE  = 6'b00_0_0_1_1;
    localparam logic [5:0] V_BR_T  = 6'b01_1_0_1_1;
    localparam logic [5:0] V_BR_N  = 6'b01_0_0_1_1;
    localparam logic [5:0] V_JMP   = 6'b10_1_0_1_1;
    localparam logic [5:0] V_SAVE  = 6'b00_0_1_1_0;
    localparam logic [5:0] V_WAIT  = 6'b11_0_0_1_0;
    localparam logic [5:0] V_EJMP  = 6'b11_1_0_1_1;

    logic [5:0] exp_q[$];
    string      nm_q[$];
    int         tests_run    = 0;
    int         tests_failed = 0;

    task automatic step(input logic s, input logic r, input logic [1:0] bt, input logic z,
                        input logic e, input logic [5:0] exp_vec, input string nm);
        @(posedge clk);
        #1;
        start    = s;
        reset    = r;
        br_type  = bt;
        alu_zero = z;
        exc_req  = e;
        exp_q.push_back(exp_vec);
        nm_q.push_back(nm);
    endtask

    // One instruction; br_type is scrambled in RESOLVE to prove it was latched in DECODE.
    task automatic run_br(input logic [1:0] bt, input logic z, input logic s_dec,
                          input logic [5:0] res_vec, input string nm);
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  {nm, "/idle"});
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_FETCH, {nm, "/fetch"});
        step(s_dec, 1'b0, bt, 1'b0, 1'b0, V_DEC,    {nm, "/decode"});
        step(1'b0, 1'b0, bt ^ 2'b11, z, 1'b0, res_vec, {nm, "/resolve"});
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  {nm, "/after"});
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  {nm, "/quiet"});
    endtask

    initial begin : monitor
        logic [5:0] act;
        logic [5:0] expv;
        string      nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                nm   = nm_q.pop_front();
                act  = {pc_src, pc_write, epc_write, busy, done};
                tests_run++;
                if (act !== expv) begin
                    tests_failed++;
                    $display("FAIL %s: got {src,pw,epcw,busy,done}=%b required %b", nm, act, expv);
                end else begin
                    $display("[TB] %-18s src=%0d pw=%b epcw=%b busy=%b done=%b ok",
                             nm, pc_src, pc_write, epc_write, busy, done);
                end
            end
        end
    end

    initial begin : stimulus
        reset    = 1'b1;
        start    = 1'b0;
        br_type  = 2'd0;
        alu_zero = 1'b0;
        exc_req  = 1'b0;

        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, V_IDLE, "reset");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE, "idle");
        end

        run_br(2'd1, 1'b1, 1'b0, V_BR_T, "beq_z1");
        run_br(2'd1, 1'b0, 1'b0, V_BR_N, "beq_z0");
        run_br(2'd2, 1'b0, 1'b0, V_BR_T, "bne_z0");
        run_br(2'd2, 1'b1, 1'b0, V_BR_N, "bne_z1");
        run_br(2'd3, 1'b0, 1'b0, V_JMP,  "jump");
        run_br(2'd0, 1'b1, 1'b1, V_NONE, "none_sdec");

        // start held high: each done is followed by one accepting IDLE cycle
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  "hold/idle0");
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, V_FETCH, "hold/fetch0");
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, V_DEC,   "hold/decode0");
        step(1'b1, 1'b0, 2'd1, 1'b1, 1'b0, V_NONE,  "hold/resolve0");
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  "hold/idle1");
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, V_FETCH, "hold/fetch1");
        step(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, V_DEC,   "hold/decode1");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_JMP,   "hold/resolve1");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  "hold/after");

        // Reset while in DECODE: IDLE at the next edge, no pending pc_write
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  "rstdec/idle");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_FETCH, "rstdec/fetch");
        step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, V_DEC,   "rstdec/decode");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  "rstdec/after");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  "rstdec/quiet");

`ifdef PC_SRC_CTRL_EXC_EN
        // Exception with br_type=j in DECODE, MEM_LAT=3
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  "exc/idle");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_FETCH, "exc/fetch");
        step(1'b0, 1'b0, 2'd3, 1'b0, 1'b1, V_DEC,   "exc/decode");
        step(1'b0, 1'b0, 2'd3, 1'b1, 1'b0, V_SAVE,  "exc/save");
        step(1'b0, 1'b0, 2'd3, 1'b1, 1'b0, V_WAIT,  "exc/wait0");
        step(1'b0, 1'b0, 2'd3, 1'b1, 1'b0, V_WAIT,  "exc/wait1");
        step(1'b0, 1'b0, 2'd3, 1'b1, 1'b0, V_WAIT,  "exc/wait2");
        step(1'b0, 1'b0, 2'd3, 1'b1, 1'b0, V_EJMP,  "exc/jump");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  "exc/after");

        // Reset during EXC_WAIT
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  "rstexc/idle");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_FETCH, "rstexc/fetch");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, V_DEC,   "rstexc/decode");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_SAVE,  "rstexc/save");
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, V_WAIT,  "rstexc/wait");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  "rstexc/after");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  "rstexc/quiet");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  "rstexc/quiet2");
`else
        // Exception path compiled out: exc_req ignored, normal jump resolve
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  "noexc/idle");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_FETCH, "noexc/fetch");
        step(1'b0, 1'b0, 2'd3, 1'b0, 1'b1, V_DEC,   "noexc/decode");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, V_JMP,   "noexc/resolve");
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, V_IDLE,  "noexc/after");
`endif

        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, V_IDLE,  "final");
        repeat (3) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
